sim_reset_seq: RTL and testbench
================================

// Module: sim_reset_seq
// PURPOSE
//  Staged reset sequencer driven directly by the simulation clock generator's clk_o.
//  Holds all domain resets for HOLD_CYCLES after the global reset releases.
//  Then releases the domain resets one at a time, lowest index first.
//  Supports soft re-sequencing on request, and reports busy/done/completed-sequence count.
// PARAMETERS
//  NUM_STAGES   3   number of staged reset outputs (>=1)
//  HOLD_CYCLES  16  clk edges all stages stay asserted before stage 0 releases (>=1)
//  STAGE_GAP    4   clk edges between release of stage k and stage k+1 (>=1)
//  CNT_W        16  counter width; HOLD_CYCLES and STAGE_GAP must be < 2**CNT_W
// PORTS
//  clk_i        in   1           clock (SimClock clk_o)
//  rst_i        in   1           synchronous, active-high reset
//  req_i        in   1           soft re-sequence request, sampled each edge
//  stage_rst_o  out  NUM_STAGES  per-domain reset, active-high, registered
//  busy_o       out  1           high while any stage_rst_o bit is high
//  done_o       out  1           one-cycle pulse when the last stage releases
//  seq_count_o  out  8           completed sequences, saturates at 255
//  ack_i        in   NUM_STAGES  only with RST_SEQ_ACK_EN; see CONFIGURATION
// BEHAVIOUR
//  - Reset (rst_i=1 at an edge): state=ASSERT, cnt=0, stage_rst_o=all 1, busy_o=1, done_o=0, seq_count_o=0.
//  - FSM states: ASSERT -> RELEASE -> RUN. All outputs are registered; all updates happen on the clk_i edge.
//  - ASSERT:
//    - cnt increments each edge.
//    - At the edge where cnt==HOLD_CYCLES-1: clear stage_rst_o[0], cnt=0, go to RELEASE (go to RUN if NUM_STAGES==1).
//    - Result: stage 0 drops at the HOLD_CYCLES-th edge after rst_i goes low.
//  - RELEASE:
//    - cnt counts 0..STAGE_GAP-1.
//    - At the edge where cnt==STAGE_GAP-1: clear the next set bit (index k+1), cnt=0.
//    - When the cleared bit is NUM_STAGES-1: go to RUN and pulse done_o on that same edge.
//  - Release order is strictly ascending. At most one bit clears per edge, and never before its gap elapses.
//  - RUN:
//    - stage_rst_o=0, busy_o=0, done_o=0 (except the single completion pulse).
//    - seq_count_o increments by 1 on the done edge, saturating at 255.
//  - req_i=1 in RUN: next edge stage_rst_o=all 1, busy_o=1, cnt=0, state=ASSERT.
//  - req_i=1 in ASSERT: cnt restarts at 0, so the hold is extended.
//  - req_i=1 in RELEASE: abort the sequence. Next edge all bits set, cnt=0, state=ASSERT, no done pulse.
//  - req_i and the final release on the same edge: req wins. All bits set, no done pulse, seq_count_o unchanged.
//  - rst_i has priority over everything, in any state and mid-sequence.
//  - busy_o == |stage_rst_o at all times (registered alongside it).
// CONFIGURATION
//  - RST_SEQ_ACK_EN defined:
//    - Port ack_i[NUM_STAGES-1:0] exists.
//    - Stage k+1 releases only at an edge where its gap has elapsed AND ack_i[k]==1.
//    - While waiting, cnt holds at STAGE_GAP-1.
//    - ack_i[NUM_STAGES-1] is unused.
//    - req_i and rst_i behave as above while waiting.
//  - RST_SEQ_ACK_EN undefined: no ack_i port; release is purely time-based.
// TESTING (defaults NUM_STAGES=3, HOLD_CYCLES=16, STAGE_GAP=4)
//  1. rst_i=1 for 5 edges, then 0
//     -> stage_rst_o=3'b111 through edge 15.
//     -> 3'b110 after edge 16, 3'b100 after edge 20, 3'b000 after edge 24.
//     -> done_o=1 for 1 cycle at edge 24; busy_o=0; seq_count_o=1.
//  2. 1-cycle req_i pulse in RUN
//     -> 3'b111 and busy_o=1 next edge.
//     -> same 16/4/4 release timing follows; seq_count_o=2.
//  3. req_i pulse 2 edges after stage 0 releases
//     -> 3'b111 next edge; full 16-edge hold restarts.
//     -> exactly one done_o pulse, at the end of the new sequence.
//  4. rst_i=1 for one edge while stage_rst_o=3'b100
//     -> 3'b111, seq_count_o=0, done_o=0; the sequence repeats after release.
//  5. 260 back-to-back sequences via req_i
//     -> seq_count_o saturates at 255; done_o still pulses every sequence.
//  6. RST_SEQ_ACK_EN, ack_i=3'b000 after reset
//     -> stage_rst_o stays 3'b110 indefinitely.
//     -> ack_i[0]=1 at edge 40 gives 3'b100 at edge 40.
//     -> ack_i[1]=1 already high gives 3'b000 at edge 44.

Source files
------------

// File: rtl/sim_reset_seq.sv
// sim_reset_seq: staged reset sequencer; holds all domain resets, then releases them lowest index first.
// Optional feature: define RST_SEQ_ACK_EN to add ack_i, gating each later release on the previous domain's ack.
module sim_reset_seq #(
    parameter int NUM_STAGES  = 3,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 4,
    parameter int CNT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_i,
`ifdef RST_SEQ_ACK_EN
    input  logic [NUM_STAGES-1:0] ack_i,
`endif
    output logic [NUM_STAGES-1:0] stage_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [7:0]            seq_count_o
);

    localparam logic [1:0] ST_ASSERT  = 2'd0;
    localparam logic [1:0] ST_RELEASE = 2'd1;
    localparam logic [1:0] ST_RUN     = 2'd2;

    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_STAGES - 1);

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] stage_q, stage_d;
    logic                  busy_q;
    logic                  done_q, done_d;
    logic [7:0]            count_q, count_d;
    logic                  ack_ok;
    logic [7:0]            count_inc;

`ifdef RST_SEQ_ACK_EN
    // idx_q names the stage about to release; it waits on the ack of the stage before it
    assign ack_ok = ack_i[idx_q - 1'b1];
`else
    assign ack_ok = 1'b1;
`endif

    assign count_inc = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

    // Next-state: hold, staged release, idle; a request always restarts from a full hold
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        stage_d = stage_q;
        done_d  = 1'b0;
        count_d = count_q;
        if (state_q == ST_ASSERT) begin
            if (req_i) begin
                cnt_d = '0;
            end else if (cnt_q == HOLD_LAST) begin
                stage_d[0] = 1'b0;
                cnt_d      = '0;
                idx_d      = IDX_W'(1);
                if (NUM_STAGES == 1) begin
                    state_d = ST_RUN;
                    done_d  = 1'b1;
                    count_d = count_inc;
                end else begin
                    state_d = ST_RELEASE;
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == ST_RELEASE) begin
            if (req_i) begin
                state_d = ST_ASSERT;
                stage_d = '1;
                cnt_d   = '0;
                idx_d   = '0;
            end else if (cnt_q == GAP_LAST) begin
                if (ack_ok) begin
                    stage_d[idx_q] = 1'b0;
                    cnt_d          = '0;
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_RUN;
                        done_d  = 1'b1;
                        count_d = count_inc;
                    end
                end
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (state_q == ST_RUN) begin
            stage_d = '0;
            if (req_i) begin
                state_d = ST_ASSERT;
                stage_d = '1;
                cnt_d   = '0;
                idx_d   = '0;
            end
        end else begin
            state_d = ST_ASSERT;
            stage_d = '1;
            cnt_d   = '0;
            idx_d   = '0;
        end
    end

    // State registers; busy is registered from the same next value as the stage resets
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_ASSERT;
            cnt_q   <= '0;
            idx_q   <= '0;
            stage_q <= '1;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            stage_q <= stage_d;
            busy_q  <= |stage_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    assign stage_rst_o = stage_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign seq_count_o = count_q;

endmodule

// File: tb/tb_sim_reset_seq.sv
// tb_sim_reset_seq: scoreboard bench; expected output changes are queued with their cycle and matched by a monitor.
module tb_sim_reset_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req = 1'b0;
    logic [2:0] stage;
    logic       busy;
    logic       done;
    logic [7:0] cnt;
`ifdef RST_SEQ_ACK_EN
    logic [2:0] ack = 3'b111;
`endif

    sim_reset_seq dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_i       (req),
`ifdef RST_SEQ_ACK_EN
        .ack_i       (ack),
`endif
        .stage_rst_o (stage),
        .busy_o      (busy),
        .done_o      (done),
        .seq_count_o (cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cy;
        logic [2:0] st;
        logic       dn;
        logic [7:0] sc;
    } ev_t;

    ev_t q[$];
    int total = 0;
    int bad = 0;
    int r = 0;
    int c = 0;

    function automatic logic [7:0] sat(input int v);
        return (v > 255) ? 8'd255 : 8'(v);
    endfunction

    task automatic push(input int cy, input logic [2:0] st, input logic dn, input logic [7:0] sc);
        ev_t e;
        e.cy = cy; e.st = st; e.dn = dn; e.sc = sc;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input int n);
        while (cyc < n) step();
    endtask

    // Expected changes of one hold/release sequence whose first counted edge is r0+1
    task automatic seq(input int r0, input int c0, input bit chain);
        push(r0 + 16, 3'b110, 1'b0, sat(c0));
        push(r0 + 20, 3'b100, 1'b0, sat(c0));
        push(r0 + 24, 3'b000, 1'b1, sat(c0 + 1));
        if (chain) push(r0 + 25, 3'b111, 1'b0, sat(c0 + 1));
        else       push(r0 + 25, 3'b000, 1'b0, sat(c0 + 1));
    endtask

    // One-edge request from RUN; the edge after it starts a new hold
    task automatic kick();
        push(cyc + 1, 3'b111, 1'b0, sat(c));
        req = 1'b1;
        step();
        req = 1'b0;
        r = cyc;
    endtask

    logic [11:0] prev = 'x;
    always @(negedge clk) begin
        if (cyc >= 1) begin
            total++;
            if (busy !== |stage) begin
                bad++;
                $display("FAIL busy cyc=%0d got=%b want=%b", cyc, busy, |stage);
            end
            if ({stage, done, cnt} !== prev) begin
                prev = {stage, done, cnt};
                total++;
                if (q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_change cyc=%0d got stage=%b done=%b cnt=%0d want no change", cyc, stage, done, cnt);
                end else begin
                    ev_t e;
                    e = q.pop_front();
                    if (e.cy != cyc || e.st !== stage || e.dn !== done || e.sc !== cnt) begin
                        bad++;
                        $display("FAIL event got cyc=%0d stage=%b done=%b cnt=%0d want cyc=%0d stage=%b done=%b cnt=%0d",
                                 cyc, stage, done, cnt, e.cy, e.st, e.dn, e.sc);
                    end
                end
            end
        end
    end

    initial begin
        push(1, 3'b111, 1'b0, 8'd0);
        go_to(5);
        rst = 1'b0;
        r = 5;
        seq(r, c, 1'b0);
        go_to(r + 26);
        c++;
        kick();
        seq(r, c, 1'b0);
        go_to(r + 26);
        c++;
        kick();
        go_to(r + 9);
        req = 1'b1;
        step();
        req = 1'b0;
        r = cyc;
        seq(r, c, 1'b0);
        go_to(r + 26);
        c++;
        kick();
        push(r + 16, 3'b110, 1'b0, sat(c));
        go_to(r + 17);
        push(r + 18, 3'b111, 1'b0, sat(c));
        req = 1'b1;
        step();
        req = 1'b0;
        r = cyc;
        seq(r, c, 1'b0);
        go_to(r + 26);
        c++;
        kick();
        push(r + 16, 3'b110, 1'b0, sat(c));
        push(r + 20, 3'b100, 1'b0, sat(c));
        go_to(r + 21);
        push(r + 22, 3'b111, 1'b0, 8'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        c = 0;
        r = cyc;
        seq(r, c, 1'b0);
        go_to(r + 26);
        c++;
        kick();
        push(r + 16, 3'b110, 1'b0, sat(c));
        push(r + 20, 3'b100, 1'b0, sat(c));
        go_to(r + 23);
        push(r + 24, 3'b111, 1'b0, sat(c));
        req = 1'b1;
        step();
        req = 1'b0;
        r = cyc;
        seq(r, c, 1'b0);
        go_to(r + 26);
        c++;
        kick();
        for (int i = 0; i < 260; i++) begin
            seq(r, c, i < 259);
            if (i < 259) begin
                go_to(r + 24);
                req = 1'b1;
                step();
                req = 1'b0;
                r = cyc;
            end else begin
                go_to(r + 26);
            end
            c++;
        end
        total++;
        if (cnt !== 8'd255) begin
            bad++;
            $display("FAIL saturate got=%0d want=255", cnt);
        end
`ifdef RST_SEQ_ACK_EN
        ack = 3'b000;
        push(cyc + 1, 3'b111, 1'b0, 8'd0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        r = cyc;
        push(r + 16, 3'b110, 1'b0, 8'd0);
        go_to(r + 30);
        ack = 3'b010;
        go_to(r + 39);
        ack = 3'b011;
        push(r + 40, 3'b100, 1'b0, 8'd0);
        push(r + 44, 3'b000, 1'b1, 8'd1);
        push(r + 45, 3'b000, 1'b0, 8'd1);
        go_to(r + 47);
        ack = 3'b111;
`endif
        go_to(cyc + 3);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL leftover got=%0d pending want=0 (next cyc=%0d)", q.size(), q[0].cy);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
